decoder_nx_scan: RTL and testbench



---
 rtl/decoder_nx_scan.sv | 96 +++++++++
 tb/tb_decoder_nx_scan.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nx_scan.sv
// decoder_nx_scan
//   Registered N-to-2^N one-hot decoder with two modes.
//   Direct: a code captured on load selects the active line.
//   Scan:   an internal index visits every line in turn, holding each one
//           for DWELL cycles, and pulses wrap when it rolls over to line 0.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   en    in   output enable; low blanks Y, clears wrap and freezes state
//   mode  in   0 = direct decode, 1 = scan
//   load  in   capture A into the index (either mode; wins over advance)
//   A     in   [N-1:0] select code
//   Y     out  [2^N-1:0] registered one-hot of idx, or all-zeros
//   idx   out  [N-1:0] registered current index
//   wrap  out  one-cycle pulse when the scan index advances 2^N-1 -> 0
module decoder_nx_scan #(
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      A,
  output logic [(1<<N)-1:0] Y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W    = 1 << N;
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  logic [N-1:0]    idx_q,   idx_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            mode_q,  mode_d;
  logic [W-1:0]    y_q,     y_d;
  logic            wrap_q,  wrap_d;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
    onehot = W'(1) << i;
  endfunction

  // Next-state: Y is derived from the index value being written on the same
  // edge, so Y and idx can never disagree.
  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    y_d     = '0;
    wrap_d  = 1'b0;
    if (en) begin
      mode_d = mode;
      if (load) begin
        idx_d   = A;
        dwell_d = '0;
      end else if (!mode || (mode != mode_q)) begin
        // Direct mode keeps the counter parked; a mode change restarts the
        // dwell so the first scanned line gets its full time.
        dwell_d = '0;
      end else if (dwell_q == DW_LAST) begin
        dwell_d = '0;
        idx_d   = idx_q + 1'b1;
        wrap_d  = (idx_q == '1);
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
      y_d = onehot(idx_d);
    end
  end

  // mode_q resets to direct, so leaving reset in scan mode counts as a mode
  // change and line 0 is shown for a full DWELL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nx_scan.sv
module tb_decoder_nx_scan;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        en4 = 1'b0, mode4 = 1'b0, load4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [15:0] y4;
  logic [3:0]  idx4;
  logic        wrap4;

  logic        en2 = 1'b0, mode2 = 1'b0, load2 = 1'b0;
  logic [1:0]  a2 = '0;
  logic [3:0]  y2;
  logic [1:0]  idx2;
  logic        wrap2;

  int total = 0;
  int bad   = 0;

  // Reference state: index 0 = N=4/DWELL=3 instance, index 1 = N=2/DWELL=1.
  int m_idx[2], m_dw[2], m_pm[2], m_y[2], m_wrap[2];

  always #5 clk = ~clk;

  decoder_nx_scan #(.N(4), .DWELL(3)) u4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .load(load4), .A(a4),
    .Y(y4), .idx(idx4), .wrap(wrap4)
  );

  decoder_nx_scan #(.N(2), .DWELL(1)) u2 (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .load(load2), .A(a2),
    .Y(y2), .idx(idx2), .wrap(wrap2)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_dw[k] = 0; m_pm[k] = 0; m_y[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int n, input int dwell,
                            input bit e, input bit m, input bit l, input int a);
    int w;
    w = 0;
    if (!e) begin
      m_y[k] = 0;
      m_wrap[k] = 0;
    end else begin
      if (l) begin
        m_idx[k] = a % (1 << n);
        m_dw[k] = 0;
      end else if (!m || (int'(m) != m_pm[k])) begin
        m_dw[k] = 0;
      end else if (m_dw[k] + 1 == dwell) begin
        m_dw[k] = 0;
        if (m_idx[k] == (1 << n) - 1) w = 1;
        m_idx[k] = (m_idx[k] + 1) % (1 << n);
      end else begin
        m_dw[k] = m_dw[k] + 1;
      end
      m_pm[k] = int'(m);
      m_y[k] = 1 << m_idx[k];
      m_wrap[k] = w;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_step(0, 4, 3, en4, mode4, load4, int'(a4));
      model_step(1, 2, 1, en2, mode2, load2, int'(a2));
    end
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    model_reset();
    #1;
    if (y4 !== 16'h0) begin bad++; $display("FAIL reset_y4 got=%h exp=0000", y4); end
    total++;
    if (idx4 !== 4'h0) begin bad++; $display("FAIL reset_idx4 got=%0d exp=0", idx4); end
    total++;
    if (wrap4 !== 1'b0) begin bad++; $display("FAIL reset_wrap4 got=%b exp=0", wrap4); end
    total++;
    if (y2 !== 4'h0) begin bad++; $display("FAIL reset_y2 got=%h exp=0", y2); end
    total++;
    if (idx2 !== 2'h0) begin bad++; $display("FAIL reset_idx2 got=%0d exp=0", idx2); end
    total++;
    if (wrap2 !== 1'b0) begin bad++; $display("FAIL reset_wrap2 got=%b exp=0", wrap2); end
    total++;
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_direct();
    en4 = 1'b1; mode4 = 1'b0; load4 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      a4 = 4'(a);
      tick();
      if (y4 !== 16'(1 << a)) begin bad++; $display("FAIL direct_y a=%0d got=%h exp=%h", a, y4, 16'(1 << a)); end
      total++;
      if (idx4 !== 4'(a)) begin bad++; $display("FAIL direct_idx got=%0d exp=%0d", idx4, a); end
      total++;
      if (wrap4 !== 1'b0) begin bad++; $display("FAIL direct_wrap a=%0d got=%b exp=0", a, wrap4); end
      total++;
    end
    load4 = 1'b0;
    tick();
    if (y4 !== 16'h8000) begin bad++; $display("FAIL direct_hold got=%h exp=8000", y4); end
    total++;
  endtask

  task automatic test_scan_sweep();
    int ei;
    bit ew;
    en4 = 1'b1; mode4 = 1'b1; load4 = 1'b0;
    pulse_reset();
    for (int k = 1; k <= 150; k++) begin
      tick();
      ei = ((k - 1) / 3) % 16;
      ew = (k > 1) && ((k - 1) % 48 == 0);
      if (y4 !== 16'(1 << ei)) begin bad++; $display("FAIL sweep_y edge=%0d got=%h exp=%h", k, y4, 16'(1 << ei)); end
      total++;
      if (idx4 !== 4'(ei)) begin bad++; $display("FAIL sweep_idx edge=%0d got=%0d exp=%0d", k, idx4, ei); end
      total++;
      if (wrap4 !== ew) begin bad++; $display("FAIL sweep_wrap edge=%0d got=%b exp=%b", k, wrap4, ew); end
      total++;
    end
  endtask

  task automatic test_load_mid();
    en4 = 1'b1; mode4 = 1'b1; load4 = 1'b0;
    pulse_reset();
    for (int k = 1; k <= 17; k++) tick();
    if (idx4 !== 4'd5) begin bad++; $display("FAIL loadmid_pre got=%0d exp=5", idx4); end
    total++;
    load4 = 1'b1; a4 = 4'd13;
    tick();
    load4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (y4 !== 16'h2000) begin bad++; $display("FAIL loadmid_y step=%0d got=%h exp=2000", k, y4); end
      total++;
      if (idx4 !== 4'd13) begin bad++; $display("FAIL loadmid_idx step=%0d got=%0d exp=13", k, idx4); end
      total++;
      tick();
    end
    if (y4 !== 16'h4000) begin bad++; $display("FAIL loadmid_next got=%h exp=4000", y4); end
    total++;
    for (int k = 0; k < 5; k++) tick();
    if (idx4 !== 4'd15) begin bad++; $display("FAIL loadwrap_pre got=%0d exp=15", idx4); end
    total++;
    load4 = 1'b1; a4 = 4'd0;
    tick();
    load4 = 1'b0;
    if (idx4 !== 4'd0) begin bad++; $display("FAIL loadwrap_idx got=%0d exp=0", idx4); end
    total++;
    if (y4 !== 16'h0001) begin bad++; $display("FAIL loadwrap_y got=%h exp=0001", y4); end
    total++;
    if (wrap4 !== 1'b0) begin bad++; $display("FAIL loadwrap_wrap got=%b exp=0", wrap4); end
    total++;
    tick();
    if (wrap4 !== 1'b0) begin bad++; $display("FAIL loadwrap_after got=%b exp=0", wrap4); end
    total++;
  endtask

  task automatic test_en_freeze();
    en4 = 1'b1; mode4 = 1'b1; load4 = 1'b0;
    pulse_reset();
    for (int k = 1; k <= 23; k++) tick();
    if (idx4 !== 4'd7) begin bad++; $display("FAIL freeze_pre got=%0d exp=7", idx4); end
    total++;
    en4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (y4 !== 16'h0) begin bad++; $display("FAIL freeze_y step=%0d got=%h exp=0000", k, y4); end
      total++;
      if (idx4 !== 4'd7) begin bad++; $display("FAIL freeze_idx step=%0d got=%0d exp=7", k, idx4); end
      total++;
    end
    en4 = 1'b1;
    tick();
    if (y4 !== 16'h0080) begin bad++; $display("FAIL resume_y got=%h exp=0080", y4); end
    total++;
    tick();
    if (y4 !== 16'h0100) begin bad++; $display("FAIL resume_next got=%h exp=0100", y4); end
    total++;
  endtask

  task automatic test_async_reset();
    en4 = 1'b1; mode4 = 1'b1; load4 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    if (y4 !== 16'h0) begin bad++; $display("FAIL arst_y got=%h exp=0000", y4); end
    total++;
    if (idx4 !== 4'h0) begin bad++; $display("FAIL arst_idx got=%0d exp=0", idx4); end
    total++;
    if (wrap4 !== 1'b0) begin bad++; $display("FAIL arst_wrap got=%b exp=0", wrap4); end
    total++;
    tick();
    if (y4 !== 16'h0) begin bad++; $display("FAIL arst_hold got=%h exp=0000", y4); end
    total++;
    #2 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (y4 !== ((k <= 3) ? 16'h0001 : 16'h0002)) begin
        bad++; $display("FAIL arst_resume edge=%0d got=%h exp=%h", k, y4, (k <= 3) ? 16'h0001 : 16'h0002);
      end
      total++;
    end
  endtask

  task automatic test_small();
    int ei;
    bit ew;
    en4 = 1'b0;
    en2 = 1'b1; mode2 = 1'b1; load2 = 1'b0;
    pulse_reset();
    for (int k = 1; k <= 9; k++) begin
      tick();
      ei = (k - 1) % 4;
      ew = (k > 1) && ((k - 1) % 4 == 0);
      if (y2 !== 4'(1 << ei)) begin bad++; $display("FAIL small_y edge=%0d got=%h exp=%h", k, y2, 4'(1 << ei)); end
      total++;
      if (wrap2 !== ew) begin bad++; $display("FAIL small_wrap edge=%0d got=%b exp=%b", k, wrap2, ew); end
      total++;
    end
    mode2 = 1'b0;
    tick();
    if (idx2 !== 2'd0) begin bad++; $display("FAIL toggle_direct got=%0d exp=0", idx2); end
    total++;
    mode2 = 1'b1;
    tick();
    if (y2 !== 4'h1) begin bad++; $display("FAIL toggle_enter got=%h exp=1", y2); end
    total++;
    tick();
    if (y2 !== 4'h2) begin bad++; $display("FAIL toggle_adv got=%h exp=2", y2); end
    total++;
  endtask

  task automatic test_random();
    en4 = 1'b1; mode4 = 1'b1; load4 = 1'b0;
    en2 = 1'b1; mode2 = 1'b1; load2 = 1'b0;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      en4 = ($urandom_range(0, 9) != 0);
      load4 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) mode4 = ~mode4;
      a4 = 4'($urandom);
      en2 = ($urandom_range(0, 9) != 0);
      load2 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) mode2 = ~mode2;
      a2 = 2'($urandom);
      tick();
      if (y4 !== 16'(m_y[0]) || idx4 !== 4'(m_idx[0]) || wrap4 !== m_wrap[0][0]) begin
        bad++;
        $display("FAIL rand4 i=%0d got y=%h idx=%0d wrap=%b exp y=%h idx=%0d wrap=%0d",
                 i, y4, idx4, wrap4, 16'(m_y[0]), m_idx[0], m_wrap[0]);
      end
      total++;
      if (y2 !== 4'(m_y[1]) || idx2 !== 2'(m_idx[1]) || wrap2 !== m_wrap[1][0]) begin
        bad++;
        $display("FAIL rand2 i=%0d got y=%h idx=%0d wrap=%b exp y=%h idx=%0d wrap=%0d",
                 i, y2, idx2, wrap2, 4'(m_y[1]), m_idx[1], m_wrap[1]);
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_sweep();
    test_load_mid();
    test_en_freeze();
    test_async_reset();
    test_small();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
